// File: rtl/multicycle_alu_if.sv
// Request/result bus of the multicycle ALU.
//
// Handshake: a transfer happens on a rising clk edge when the producer's
// valid and the consumer's ready are both 1 in the cycle before that edge.
// A producer holds valid and its payload stable until the transfer; ready
// may change freely and never depends on the partner's ready.
//   request : Valid_i / Ready_o with ALUCtl_i, Op1_i, Op2_i
//   result  : Valid_o / Ready_i with Res_o, Overflow_o
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             Valid_i;
    logic             Ready_o;
    logic [3:0]       ALUCtl_i;
    logic [WIDTH-1:0] Op1_i;
    logic [WIDTH-1:0] Op2_i;
    logic             Valid_o;
    logic             Ready_i;
    logic [WIDTH-1:0] Res_o;
    logic             Overflow_o;

    // ALU side
    modport slave (
        input  Valid_i, ALUCtl_i, Op1_i, Op2_i, Ready_i,
        output Ready_o, Valid_o, Res_o, Overflow_o
    );

    // Requester/consumer side
    modport master (
        output Valid_i, ALUCtl_i, Op1_i, Op2_i, Ready_i,
        input  Ready_o, Valid_o, Res_o, Overflow_o
    );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU with a three-state control FSM (IDLE, BUSY, DONE).
// Single-cycle ops (ADD, SUB, SLT, SLTU, XOR, OR, AND, undefined codes) are
// computed at accept and go straight to DONE. Shifts move one bit per BUSY
// cycle; MUL is a shift-add multiplier running WIDTH BUSY cycles.
// Optional feature macro: ALU_MUL_EN (defined -> MUL 4'b1001 implemented,
// undefined -> 4'b1001 behaves as an undefined code and no multiplier exists).
// dbg_state exposes the FSM state: 0 IDLE, 1 BUSY, 2 DONE.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_alu_if.slave      bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1001;
`endif

    state_t               state;
    state_t               state_next;

    logic [3:0]           op_q;
    logic [WIDTH-1:0]     res_q;
    logic                 ovf_q;
    logic [SHAMT_W:0]     cnt_q;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]     mcand_q;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier_q;  // multiplier, shifted right each step
`endif

    logic                 accept;
    logic                 step;
    logic                 is_shift_in;
    logic                 is_mul_in;
    logic                 multi_in;
    logic [SHAMT_W-1:0]   shamt_in;
    logic                 sub_in;
    logic [WIDTH-1:0]     op2_x;
    logic [WIDTH:0]       sum;
    logic                 slt_in;
    logic                 sltu_in;
    logic [WIDTH-1:0]     res_fast;
    logic                 ovf_fast;
    logic [SHAMT_W:0]     cnt_load;

    // Decode of the request fields presented this cycle
    always_comb begin
        shamt_in    = bus.Op2_i[SHAMT_W-1:0];
        is_shift_in = (bus.ALUCtl_i == OP_SLL) || (bus.ALUCtl_i == OP_SRL) ||
                      (bus.ALUCtl_i == OP_SRA);
`ifdef ALU_MUL_EN
        is_mul_in   = (bus.ALUCtl_i == OP_MUL);
`else
        is_mul_in   = 1'b0;
`endif
        // A zero-distance shift finishes like a single-cycle op
        multi_in    = is_mul_in || (is_shift_in && (shamt_in != '0));
        if (is_mul_in) begin
            cnt_load = (SHAMT_W + 1)'(WIDTH);
        end else if (is_shift_in) begin
            cnt_load = {1'b0, shamt_in};
        end else begin
            cnt_load = '0;
        end
    end

    // Shared WIDTH+1-bit sign-extended adder: subtracts for SUB, SLT, SLTU
    always_comb begin
        sub_in  = (bus.ALUCtl_i == OP_SUB) || (bus.ALUCtl_i == OP_SLT) ||
                  (bus.ALUCtl_i == OP_SLTU);
        op2_x   = sub_in ? ~bus.Op2_i : bus.Op2_i;
        sum     = {bus.Op1_i[WIDTH-1], bus.Op1_i} + {op2_x[WIDTH-1], op2_x} +
                  {{WIDTH{1'b0}}, sub_in};
        // The extra bit never overflows, so it is the true sign of Op1-Op2
        slt_in  = sum[WIDTH];
        // Unsigned compare: undo the sign-extension contribution of both MSBs
        sltu_in = sum[WIDTH] ^ bus.Op1_i[WIDTH-1] ^ bus.Op2_i[WIDTH-1];
    end

    // Result loaded at accept: final value for single-cycle ops, start value otherwise
    always_comb begin
        res_fast = '0;
        ovf_fast = 1'b0;
        case (bus.ALUCtl_i)
            OP_ADD, OP_SUB: begin
                res_fast = sum[WIDTH-1:0];
                ovf_fast = sum[WIDTH] ^ sum[WIDTH-1];
            end
            OP_SLT:  res_fast = {{(WIDTH-1){1'b0}}, slt_in};
            OP_SLTU: res_fast = {{(WIDTH-1){1'b0}}, sltu_in};
            OP_XOR:  res_fast = bus.Op1_i ^ bus.Op2_i;
            OP_OR:   res_fast = bus.Op1_i | bus.Op2_i;
            OP_AND:  res_fast = bus.Op1_i & bus.Op2_i;
            OP_SLL, OP_SRL, OP_SRA: res_fast = bus.Op1_i;
`ifdef ALU_MUL_EN
            OP_MUL:  res_fast = '0;  // accumulator starts empty
`endif
            default: res_fast = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        step        = 1'b0;
        bus.Ready_o = (state == IDLE);
        bus.Valid_o = (state == DONE);
        case (state)
            IDLE: begin
                if (bus.Valid_i && !rst_i) begin
                    accept     = 1'b1;
                    state_next = multi_in ? BUSY : DONE;
                end
            end
            BUSY: begin
                step = 1'b1;
                // Last step happens while the counter still reads 1
                if (cnt_q <= (SHAMT_W + 1)'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.Ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operation capture and per-cycle shift / shift-add datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else if (accept) begin
            op_q     <= bus.ALUCtl_i;
            res_q    <= res_fast;
            ovf_q    <= ovf_fast;
            cnt_q    <= cnt_load;
`ifdef ALU_MUL_EN
            mcand_q  <= bus.Op1_i;
            mplier_q <= bus.Op2_i;
`endif
        end else if (step) begin
            cnt_q <= cnt_q - (SHAMT_W + 1)'(1);
            case (op_q)
                OP_SLL: res_q <= {res_q[WIDTH-2:0], 1'b0};
                OP_SRL: res_q <= {1'b0, res_q[WIDTH-1:1]};
                OP_SRA: res_q <= {res_q[WIDTH-1], res_q[WIDTH-1:1]};
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    if (mplier_q[0]) begin
                        res_q <= res_q + mcand_q;
                    end
                    mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                end
`endif
                default: res_q <= res_q;
            endcase
        end
    end

    assign bus.Res_o      = res_q;
    assign bus.Overflow_o = ovf_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): a behavioural model
// predicts result, overflow and latency per accepted request; one compare
// process checks Ready_o, Valid_o, Res_o and Overflow_o every cycle.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dbg_state;
    int          cyc = 0;

    int          checks = 0;
    int          errors = 0;

    // model state
    logic [31:0] exp_q[$];
    logic        exp_ovf_q[$];
    int          lat_q[$];
    bit          busy = 0;
    int          acc_cyc = 0;
    bit          in_rst = 1;
    bit          hs_pending = 0;
    int          hold = 0;

    multicycle_alu_if #(.WIDTH(32)) bus ();

    multicycle_alu #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // behavioural model: result, overflow and latency straight from the op definitions
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v, output int lat);
        longint s;
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'h0;
        v   = 1'b0;
        lat = 1;
        case (op)
            4'b0000: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            4'b1000: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b0001: begin r = a << sh; lat = sh + 1; end
            4'b0101: begin r = a >> sh; lat = sh + 1; end
            4'b1101: begin r = $signed(a) >>> sh; lat = sh + 1; end
`ifdef ALU_MUL_EN
            4'b1001: begin r = a * b; lat = 33; end
`endif
            default: r = 32'h0;
        endcase
    endfunction

    task automatic drive_junk();
        bus.Valid_i  = 1'($urandom_range(0, 1));
        bus.ALUCtl_i = 4'($urandom_range(0, 15));
        bus.Op1_i    = $urandom;
        bus.Op2_i    = $urandom;
    endtask

    // driver: present one request in the first cycle the model says the ALU is idle
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic v;
        int lat;
        bit waiting;
        waiting = 1;
        while (waiting) begin
            @(negedge clk);
            #1;
            if (!busy) waiting = 0;
            else drive_junk();
        end
        bus.Valid_i  = 1'b1;
        bus.ALUCtl_i = op;
        bus.Op1_i    = a;
        bus.Op2_i    = b;
        model(op, a, b, r, v, lat);
        exp_q.push_back(r);
        exp_ovf_q.push_back(v);
        lat_q.push_back(lat);
        acc_cyc = cyc;
        busy    = 1;
        @(posedge clk);
        #1;
        drive_junk();
    endtask

    task automatic wait_idle();
        while (busy) @(negedge clk);
        bus.Valid_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // compare process and result consumer
    initial begin
        bit exp_valid;
        bus.Ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                bus.Ready_i = 1'b0;
                hs_pending  = 0;
            end else begin
                if (hs_pending) begin
                    void'(exp_q.pop_front());
                    void'(exp_ovf_q.pop_front());
                    void'(lat_q.pop_front());
                    busy       = 0;
                    hs_pending = 0;
                end
                check("ready_o", 64'(bus.Ready_o), 64'(!busy));
                exp_valid = busy && (lat_q.size() > 0) && ((cyc - acc_cyc) >= lat_q[0]);
                check("valid_o", 64'(bus.Valid_o), 64'(exp_valid));
                if (exp_valid) begin
                    check("res_o", 64'(bus.Res_o), 64'(exp_q[0]));
                    check("overflow_o", 64'(bus.Overflow_o), 64'(exp_ovf_q[0]));
                end
                if (exp_valid && hold > 0) begin
                    bus.Ready_i = 1'b0;
                    hold--;
                end else begin
                    bus.Ready_i = ($urandom_range(0, 3) != 0);
                end
                if (exp_valid && bus.Ready_i) hs_pending = 1;
            end
        end
    end

    // watchdog: a stalled DUT still ends in a summary line
    initial begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: cycle budget of %0d expired, busy=%0d", 60000, busy);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // main sequence
    initial begin
        logic [31:0] r;
        logic v;
        int lat;
        logic [3:0] codes[11] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                  4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001};
        rst          = 1'b1;
        in_rst       = 1;
        bus.Valid_i  = 1'b0;
        bus.ALUCtl_i = 4'h0;
        bus.Op1_i    = 32'h0;
        bus.Op2_i    = 32'h0;

        // model pins
        model(4'b1000, 32'h8000_0000, 32'h1, r, v, lat);
        check("model_sub_res", 64'(r), 64'h7FFF_FFFF);
        check("model_sub_ovf", 64'(v), 64'h1);
        model(4'b0010, 32'hFFFF_FFFF, 32'h1, r, v, lat);
        check("model_slt", 64'(r), 64'h1);
        model(4'b0011, 32'hFFFF_FFFF, 32'h1, r, v, lat);
        check("model_sltu", 64'(r), 64'h0);
        model(4'b1101, 32'h8000_0000, 32'h24, r, v, lat);
        check("model_sra_res", 64'(r), 64'hF800_0000);
        check("model_sra_lat", 64'(lat), 64'd5);
        model(4'b1001, 32'hFFFF_FFFF, 32'h3, r, v, lat);
`ifdef ALU_MUL_EN
        check("model_mul_res", 64'(r), 64'hFFFF_FFFD);
        check("model_mul_lat", 64'(lat), 64'd33);
`else
        check("model_mul_res", 64'(r), 64'h0);
        check("model_mul_lat", 64'(lat), 64'd1);
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("reset_valid_o", 64'(bus.Valid_o), 64'h0);
        check("reset_res_o", 64'(bus.Res_o), 64'h0);
        check("reset_overflow_o", 64'(bus.Overflow_o), 64'h0);
        check("reset_state", 64'(dbg_state), 64'h0);
        rst    = 1'b0;
        in_rst = 0;

        // directed vectors
        send(4'b1000, 32'h8000_0000, 32'h1);
        send(4'b0010, 32'hFFFF_FFFF, 32'h1);
        send(4'b0011, 32'hFFFF_FFFF, 32'h1);
        send(4'b1101, 32'h8000_0000, 32'h24);
        send(4'b1101, 32'h8000_0000, 32'h20);
        send(4'b1001, 32'hFFFF_FFFF, 32'h3);
        send(4'b0000, 32'h7FFF_FFFF, 32'h1);
        send(4'b1111, 32'h1234_5678, 32'h1);
        wait_idle();
        hold = 3;
        send(4'b0000, 32'd5, 32'd7);
        wait_idle();

        // reset in the middle of a long shift
        send(4'b0001, 32'h1234_5678, 32'd20);
        repeat (5) @(negedge clk);
        in_rst       = 1;
        rst          = 1'b1;
        bus.Valid_i  = 1'b1;
        bus.ALUCtl_i = 4'b0000;
        bus.Op1_i    = 32'd3;
        bus.Op2_i    = 32'd4;
        @(negedge clk);
        check("midreset_valid_o", 64'(bus.Valid_o), 64'h0);
        check("midreset_res_o", 64'(bus.Res_o), 64'h0);
        check("midreset_overflow_o", 64'(bus.Overflow_o), 64'h0);
        @(negedge clk);
        exp_q.delete();
        exp_ovf_q.delete();
        lat_q.delete();
        busy        = 0;
        bus.Valid_i = 1'b0;
        rst         = 1'b0;
        in_rst      = 0;
        repeat (30) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            else op = codes[$urandom_range(0, 10)];
            send(op, pick_operand(), pick_operand());
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
